pulse_train_gen: RTL and testbench



---
 rtl/pulse_train_gen.sv | 145 ++++++++++++++
 tb/tb_pulse_train_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: one-shot, counted burst or continuous waveform with runtime high/low lengths.
// Outputs are registered one cycle after the decision; start/stop are level-sampled, no backpressure.
module pulse_train_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_cnt,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_num
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_high, r_low;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_pulse_num, w_pn_nxt;
  logic             r_signal, r_busy, r_done;
  logic             w_done_nxt, w_load;
  logic [CNT_W-1:0] w_high_in, w_low_in, w_cnt_in;

  // Zero-length requests are promoted to one so every phase lasts at least a cycle.
  assign w_high_in = (high_len  == ZERO) ? ONE : high_len;
  assign w_low_in  = (low_len   == ZERO) ? ONE : low_len;
  assign w_cnt_in  = (pulse_cnt == ZERO) ? ONE : pulse_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_pn_nxt    = r_pulse_num;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_load      = 1'b1;
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = w_high_in;
          w_rem_nxt   = w_cnt_in;
          w_pn_nxt    = ONE;
        end
      end
      S_HIGH: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = ZERO;
          w_done_nxt  = 1'b1;
        end else if (r_cnt <= ONE) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = r_low;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      S_LOW: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = ZERO;
          w_done_nxt  = 1'b1;
        end else if (r_cnt <= ONE) begin
          // End of a period: the latched mode decides whether another pulse follows.
          case (r_mode)
            2'd1: begin
              if (r_rem <= ONE) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = ZERO;
                w_rem_nxt   = ZERO;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_HIGH;
                w_cnt_nxt   = r_high;
                w_rem_nxt   = r_rem - ONE;
                w_pn_nxt    = r_pulse_num + ONE;
              end
            end
            2'd2: begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = r_high;
              w_pn_nxt    = r_pulse_num + ONE;
            end
            default: begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = ZERO;
              w_done_nxt  = 1'b1;
            end
          endcase
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = ZERO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_high      <= ZERO;
      r_low       <= ZERO;
      r_cnt       <= ZERO;
      r_rem       <= ZERO;
      r_pulse_num <= ZERO;
      r_signal    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_pulse_num <= w_pn_nxt;
      r_signal    <= (w_state_nxt == S_HIGH);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      if (w_load) begin
        r_mode <= mode;
        r_high <= w_high_in;
        r_low  <= w_low_in;
      end
    end
  end

  assign signal    = r_signal;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_num = r_pulse_num;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: expected {signal,busy,done} per cycle is queued at launch and popped each cycle.
module tb_pulse_train_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, stop;
  logic [1:0] mode;
  logic [7:0] high_len, low_len, pulse_cnt;
  logic       signal, busy, done;
  logic [7:0] pulse_num;

  logic       start4, stop4;
  logic [1:0] mode4;
  logic [3:0] high4, low4, cnt4;
  logic       signal4, busy4, done4;
  logic [3:0] pn4;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [3:0] pn_q[$];

  always #5 clock = ~clock;

  pulse_train_gen #(.CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .high_len(high_len), .low_len(low_len), .pulse_cnt(pulse_cnt),
    .signal(signal), .busy(busy), .done(done), .pulse_num(pulse_num)
  );

  pulse_train_gen #(.CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start4), .stop(stop4), .mode(mode4),
    .high_len(high4), .low_len(low4), .pulse_cnt(cnt4),
    .signal(signal4), .busy(busy4), .done(done4), .pulse_num(pn4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected trace straight from the waveform definition: period h+l, high first.
  task automatic push_wave(input int h, input int l, input int ncyc, input bit with_done);
    for (int k = 1; k <= ncyc; k++)
      exp_q.push_back({(((k - 1) % (h + l)) < h), 1'b1, 1'b0});
    if (with_done) exp_q.push_back(3'b001);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(3'b000);
  endtask

  task automatic step_check();
    logic [2:0] e;
    @(negedge clock);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("wave", 32'({signal, busy, done}), 32'(e));
    end
  endtask

  task automatic drain();
    while (exp_q.size() != 0) step_check();
  endtask

  // Drives a start for one sampling edge; caller pushes the expected trace first.
  task automatic launch(input logic [1:0] m, input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
    mode = m; high_len = h; low_len = l; pulse_cnt = n; start = 1'b1;
    step_check();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    high_len = 8'd0; low_len = 8'd0; pulse_cnt = 8'd0;
    start4 = 1'b0; stop4 = 1'b0; mode4 = 2'd0; high4 = 4'd0; low4 = 4'd0; cnt4 = 4'd0;
    repeat (3) @(negedge clock);
    check_val("reset_out", 32'({signal, busy, done}), 32'd0);
    check_val("reset_pn", 32'(pulse_num), 32'd0);
    reset = 1'b1;
    push_idle(2);
    drain();

    // Burst 3/2 x3: high 1-3, 6-8, 11-13; done at 16.
    push_wave(3, 2, 15, 1'b1);
    launch(2'd1, 8'd3, 8'd2, 8'd3);
    drain();
    check_val("burst_pn", 32'(pulse_num), 32'd3);
    push_idle(2);
    drain();

    // Zero lengths, then a restart sampled in the done cycle.
    push_wave(1, 1, 2, 1'b1);
    launch(2'd0, 8'd0, 8'd0, 8'd0);
    drain();
    push_wave(1, 1, 2, 1'b1);
    launch(2'd0, 8'd0, 8'd0, 8'd0);
    drain();
    check_val("b2b_pn", 32'(pulse_num), 32'd1);
    push_idle(1);
    drain();

    // Reserved mode acts as one-shot.
    push_wave(2, 1, 3, 1'b1);
    launch(2'd3, 8'd2, 8'd1, 8'd5);
    drain();
    push_idle(1);
    drain();

    // Mid-burst input changes are ignored.
    push_wave(3, 2, 15, 1'b1);
    launch(2'd1, 8'd3, 8'd2, 8'd3);
    repeat (3) step_check();
    start = 1'b1; high_len = 8'd9; mode = 2'd2; pulse_cnt = 8'd7;
    repeat (6) step_check();
    start = 1'b0;
    drain();
    check_val("ignore_pn", 32'(pulse_num), 32'd3);

    // start together with stop in IDLE does nothing.
    start = 1'b1; stop = 1'b1;
    push_idle(4);
    drain();
    start = 1'b0; stop = 1'b0;
    check_val("startstop_pn", 32'(pulse_num), 32'd3);

    // Continuous 32/64, stop sampled at cycle 300 -> done at 301.
    push_wave(32, 64, 300, 1'b1);
    launch(2'd2, 8'd32, 8'd64, 8'd0);
    repeat (299) step_check();
    stop = 1'b1;
    step_check();
    stop = 1'b0;
    check_val("cont_pn", 32'(pulse_num), 32'd4);
    push_idle(3);
    drain();
    check_val("cont_pn_hold", 32'(pulse_num), 32'd4);

    // Reset held 3 cycles mid-waveform: outputs clear, no done afterwards.
    push_wave(5, 5, 4, 1'b0);
    launch(2'd2, 8'd5, 8'd5, 8'd0);
    drain();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_val("rst_mid_out", 32'({signal, busy, done}), 32'd0);
      check_val("rst_mid_pn", 32'(pulse_num), 32'd0);
    end
    reset = 1'b1;
    push_idle(5);
    drain();

    // CNT_W=4 wrap: pulse k starts at cycle 2k-1, count modulo 16.
    for (int c = 1; c <= 34; c++) pn_q.push_back(4'(((c + 1) / 2) % 16));
    mode4 = 2'd2; high4 = 4'd1; low4 = 4'd1; start4 = 1'b1;
    while (pn_q.size() != 0) begin
      @(negedge clock);
      start4 = 1'b0;
      check_val("pn_wrap", 32'(pn4), 32'(pn_q.pop_front()));
    end
    stop4 = 1'b1;
    @(negedge clock);
    stop4 = 1'b0;
    check_val("wrap_stop", 32'({signal4, busy4, done4}), 32'b001);
    check_val("wrap_hold", 32'(pn4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
